// File: rtl/mmu_tile_packer.sv
// Packs 32-bit words into a SIZE x SIZE byte tile and pushes it to the MMU FIFO with a one-cycle strobe.
// Latency is 2 cycles from the final word to dst_push; in_ready stays low from that word until the push completes.
module mmu_tile_packer #(
    parameter int SIZE  = 64,
    parameter int CNT_W = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [31:0]                        in_data,
    input  logic                               in_last,
    input  logic                               abort,
    input  logic                               clr_err,
    input  logic                               dst_rdy,
    output logic                               dst_push,
    output logic [7:0]                         tile_out [SIZE][SIZE],
    output logic [$clog2(SIZE*SIZE/4+1)-1:0]   word_count,
    output logic [CNT_W-1:0]                   tiles_pushed,
    output logic                               err_framing
);
    localparam int WORDS = SIZE * SIZE / 4;
    localparam int WC_W  = $clog2(WORDS + 1);
    localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;

    typedef enum logic [1:0] {INIT, FILL, WAIT, PUSH} state_t;
    state_t state;

    logic             accept;
    logic             last_word;
    logic             frame_err;
    logic [IDX_W-1:0] wr_row [4];
    logic [IDX_W-1:0] wr_col [4];

    // A word's four bytes may straddle a row boundary when SIZE is not a multiple of 4.
    always_comb begin
        accept    = (state == FILL) && !abort && in_valid && in_ready;
        last_word = (word_count == WC_W'(WORDS - 1));
        frame_err = accept && (last_word ? !in_last : in_last);
        for (int k = 0; k < 4; k++) begin
            wr_row[k] = IDX_W'((int'(word_count) * 4 + k) / SIZE);
            wr_col[k] = IDX_W'((int'(word_count) * 4 + k) % SIZE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= INIT;
            in_ready     <= 1'b0;
            dst_push     <= 1'b0;
            word_count   <= '0;
            tiles_pushed <= '0;
            err_framing  <= 1'b0;
            for (int r = 0; r < SIZE; r++) begin
                for (int c = 0; c < SIZE; c++) begin
                    tile_out[r][c] <= 8'h00;
                end
            end
        end else begin
            // A fresh framing error outranks a clear in the same cycle.
            err_framing <= frame_err || (err_framing && !clr_err);
            if (accept) begin
                for (int k = 0; k < 4; k++) begin
                    tile_out[wr_row[k]][wr_col[k]] <= in_data[8*k +: 8];
                end
            end
            case (state)
                INIT: begin
                    in_ready <= 1'b1;
                    state    <= FILL;
                end
                FILL: begin
                    if (abort) begin
                        word_count <= '0;
                    end else if (accept) begin
                        if (last_word) begin
                            in_ready   <= 1'b0;
                            word_count <= '0;
                            state      <= WAIT;
                        end else if (in_last) begin
                            word_count <= '0;
                        end else begin
                            word_count <= word_count + 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (dst_rdy) begin
                        dst_push <= 1'b1;
                        state    <= PUSH;
                    end
                end
                PUSH: begin
                    dst_push     <= 1'b0;
                    in_ready     <= 1'b1;
                    tiles_pushed <= tiles_pushed + 1'b1;
                    state        <= FILL;
                end
                default: state <= INIT;
            endcase
        end
    end
endmodule
